spram_init_seq: RTL and testbench

SPRAM_INIT_SEQ -- requirements
Module: spram_init_seq

---
 rtl/spram_init_seq.sv | 150 +++++++++++++++
 tb/tb_spram_init_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spram_init_seq.sv
// Power-on SRAM initialiser: settle wait, pattern fill, optional read-back check.
// Define SPRAM_INIT_CHECK_EN to build in the CHECK pass and the mismatch flag.
module spram_init_seq #(
    parameter int          ADDR_W      = 14,
    parameter int          DATA_W      = 16,
    parameter int          DEPTH       = 16384,
    parameter int          WAIT_CYCLES = 16,
    parameter logic [15:0] SEED        = 16'hA5A5
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              init_done,
    output logic              init_err
);

    localparam logic [15:0]       WAIT_LAST = 16'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        FILL  = 2'd1,
`ifdef SPRAM_INIT_CHECK_EN
        CHECK = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ DATA_W'(SEED);
    endfunction

    state_t              state_q, state_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic                rd_last_q, rd_last_d;
    logic                cs_d, we_d, busy_d, done_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    // Outputs are registered from the current state, so the bus lags the FSM by one edge.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_cnt_d = addr_cnt_q;
        rd_last_d  = rd_last_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = ram_addr;
        wdata_d    = ram_wdata;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        case (state_q)
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = FILL;
                else                         wait_cnt_d = wait_cnt_q + 16'd1;
            end
            FILL: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = addr_cnt_q;
                wdata_d = pattern(addr_cnt_q);
                if (addr_cnt_q == ADDR_LAST) begin
                    addr_cnt_d = '0;
`ifdef SPRAM_INIT_CHECK_EN
                    state_d    = CHECK;
`else
                    state_d    = DONE;
`endif
                end else begin
                    addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                end
            end
`ifdef SPRAM_INIT_CHECK_EN
            CHECK: begin
                if (!rd_last_q) begin
                    cs_d   = 1'b1;
                    addr_d = addr_cnt_q;
                    if (addr_cnt_q == ADDR_LAST) rd_last_d  = 1'b1;
                    else                         addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                end else begin
                    // Final cycle: no access, only the last read-back compare.
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
            addr_cnt_q <= '0;
            rd_last_q  <= 1'b0;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            rd_last_q  <= rd_last_d;
            ram_cs     <= cs_d;
            ram_we     <= we_d;
            ram_addr   <= addr_d;
            ram_wdata  <= wdata_d;
            busy       <= busy_d;
            init_done  <= done_d;
        end
    end

`ifdef SPRAM_INIT_CHECK_EN
    logic              cmp_vld_p0;
    logic [DATA_W-1:0] cmp_exp_p0;

    // p0: capture the read issued on the bus; the RAM answers during the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_vld_p0 <= 1'b0;
            init_err   <= 1'b0;
        end else begin
            cmp_vld_p0 <= ram_cs && !ram_we;
            if (cmp_vld_p0 && (ram_rdata != cmp_exp_p0)) init_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cmp_exp_p0 <= pattern(ram_addr);
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign init_err     = 1'b0;
`endif

endmodule

// File: tb/tb_spram_init_seq.sv
// Scoreboard bench for spram_init_seq with a behavioural RAM and randomised runs.
module tb_spram_init_seq;

    localparam int          ADDR_W = 14;
    localparam int          DATA_W = 16;
    localparam int          D      = 16;
    localparam int          W      = 4;
    localparam logic [15:0] SEED   = 16'hA5A5;
`ifdef SPRAM_INIT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int DONE_EDGE = CHK_EN ? (W + 2 * D + 2) : (W + D + 1);

    logic              clk;
    logic              rst_n;
    logic              ram_cs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic              init_done;
    logic              init_err;

    spram_init_seq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(D), .WAIT_CYCLES(W), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .init_done(init_done), .init_err(init_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit we;
        int addr;
        int wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc;
    int          corrupt_addr = -1;
    logic [15:0] mem [0:D-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Edge number since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Behavioural single-port RAM, one-cycle read latency; junk on rdata when not reading.
    always @(posedge clk) begin
        if (ram_cs && ram_we && int'(ram_addr) < D) mem[ram_addr] <= ram_wdata;
        if (ram_cs && !ram_we)
            ram_rdata <= (int'(ram_addr) == corrupt_addr) ? 16'h0000
                       : (int'(ram_addr) < D) ? mem[ram_addr] : 16'hDEAD;
        else
            ram_rdata <= 16'($urandom);
    end

    // Monitor: every RAM access must match the next expected transaction.
    always @(negedge clk) begin : monitor
        txn_t t;
        if (rst_n && ram_cs) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_access", ram_cs, 1'b0);
            end else begin
                t = exp_q.pop_front();
                chk("txn_cycle", cyc, t.cyc);
                chk("txn_we", ram_we, t.we);
                chk("txn_addr", ram_addr, t.addr);
                if (t.we) chk("txn_wdata", ram_wdata, t.wdata);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_cs"}, ram_cs, 1'b0);
        chk({tag, "_we"}, ram_we, 1'b0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_wdata"}, ram_wdata, 0);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_done"}, init_done, 1'b0);
        chk({tag, "_err"}, init_err, 1'b0);
    endtask

    // Reference: D writes of addr^SEED starting one edge after the wait, then D reads.
    task automatic push_model();
        txn_t t;
        for (int i = 0; i < D; i++) begin
            t.cyc = W + 1 + i; t.we = 1'b1; t.addr = i; t.wdata = i ^ int'(SEED);
            exp_q.push_back(t);
        end
        if (CHK_EN) begin
            for (int i = 0; i < D; i++) begin
                t.cyc = W + D + 1 + i; t.we = 1'b0; t.addr = i; t.wdata = 0;
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic run(input int corrupt, input int abort_at, input int hold);
        bit exp_done;
        bit exp_err;
        corrupt_addr = corrupt;
        for (int i = 0; i < D; i++) mem[i] = 16'($urandom);
        exp_q.delete();
        push_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= DONE_EDGE + hold; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                #3 rst_n = 1'b0;
                #1 check_reset("abort");
                exp_q.delete();
                return;
            end
            exp_done = (k >= DONE_EDGE);
            exp_err  = CHK_EN && (corrupt >= 0) && (k >= W + D + corrupt + 3);
            chk("init_done", init_done, exp_done);
            chk("busy", busy, !exp_done);
            chk("init_err", init_err, exp_err);
            if (exp_done) begin
                chk("done_cs", ram_cs, 1'b0);
                chk("done_we", ram_we, 1'b0);
            end
        end
        chk("all_txns_seen", exp_q.size(), 0);
        #3 rst_n = 1'b0;
        #1 check_reset("rerst");
    endtask

    initial begin
        int c;
        int a;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");

        run(-1, 0, 100);
        run(7, 0, 5);
        run(-1, W + 1 + 9, 0);
        run(-1, 0, 3);
        run(15, 0, 3);
        run(0, 0, 3);

        for (int r = 0; r < 6; r++) begin
            c = int'($urandom_range(16, 0)) - 1;
            a = ($urandom_range(1, 0) == 1) ? int'($urandom_range(DONE_EDGE - 1, 1)) : 0;
            run(c, a, 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
